sqrt_arbiter: RTL

Shares one fully-pipelined 16-bit square-root core (AXI-stream cartesian in, dout out, no backpressure) among NREQ independent requesters. Grants are round-robin, one operand per cycle, and each operand's requester ID is tracked in an in-order tag FIFO so every result returns to the requester that issued it. The block sits between the DVP pixel-processing clients and the single `sqrt` instance, so the core never needs duplicating.

---
 rtl/sqrt_arbiter_if.sv | 22 ++
 rtl/sqrt_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sqrt_arbiter_if.sv
// Requester-side bundle for sqrt_arbiter: operand handshake in, tagged results out.
// An operand moves on a cycle where req_valid[i] && req_ready[i]; req_ready may depend on req_valid.
// resp_valid is a one-cycle strobe with no backpressure.
interface sqrt_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    resp_valid;
  logic [15:0]        resp_data;

  modport master (
    output req_valid, req_data,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// Round-robin sharing of one pipelined sqrt core among NREQ requesters.
// Issued requester IDs ride an in-order tag FIFO so each result returns to its issuer.
module sqrt_arbiter #(
  parameter int NREQ         = 4,
  parameter int CORE_LAT     = 16,
  parameter int MAX_INFLIGHT = 32
) (
  input  logic         clk,
  input  logic         rst,
  sqrt_arbiter_if.slave req_if,
  output logic [15:0]  sqrt_din,
  output logic         sqrt_vin,
  input  logic [15:0]  sqrt_dout,
  input  logic         sqrt_vout,
  output logic         busy,
  output logic         err
);

  localparam int TAG_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(MAX_INFLIGHT);
  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam int DRN_W = $clog2(CORE_LAT + 2);

  logic [TAG_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] tag_mem_q [MAX_INFLIGHT];
  logic [TAG_W-1:0] tag_mem_d [MAX_INFLIGHT];
  logic [DRN_W-1:0] drain_q, drain_d;
  logic [15:0]      din_q, din_d;
  logic             vin_q, vin_d;
  logic [NREQ-1:0]  resp_valid_q, resp_valid_d;
  logic [15:0]      resp_data_q, resp_data_d;
  logic             err_q, err_d;

  logic [15:0]      op [NREQ];
  logic [TAG_W-1:0] idx;
  logic [TAG_W-1:0] cand;
  logic             found;
  logic             drain_active;
  logic             grant_ok;
  logic             pop;
  logic             orphan;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      op[i] = req_if.req_data[16*i +: 16];
    end
  end

  // Search starts one past the last winner so every active requester gets a turn.
  always_comb begin
    cand  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = TAG_W'((int'(rr_q) + i) % NREQ);
      if (!found && req_if.req_valid[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  assign drain_active = (drain_q != '0);
  // The gate sees the pre-update count, so a pop in the same cycle cannot open an extra slot.
  assign grant_ok     = found && !drain_active && (inflight_q < CNT_W'(MAX_INFLIGHT));
  assign pop          = sqrt_vout && !drain_active && (inflight_q != '0);
  assign orphan       = sqrt_vout && !drain_active && (inflight_q == '0);

  always_comb begin
    rr_d         = rr_q;
    inflight_d   = inflight_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    tag_mem_d    = tag_mem_q;
    drain_d      = drain_q;
    din_d        = din_q;
    vin_d        = 1'b0;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    err_d        = err_q;

    if (grant_ok) begin
      din_d               = op[cand];
      vin_d               = 1'b1;
      tag_mem_d[wr_ptr_q] = cand;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
      rr_d                = cand;
    end

    if (pop) begin
      resp_valid_d = NREQ'(1) << tag_mem_q[rd_ptr_q];
      resp_data_d  = sqrt_dout;
      rd_ptr_d     = rd_ptr_q + PTR_W'(1);
    end

    case ({grant_ok, pop})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (orphan) begin
      err_d = 1'b1;
    end

    if (drain_active) begin
      drain_d = drain_q - DRN_W'(1);
    end
  end

  // The core has no reset: results from before rst may still emerge, so they are
  // swallowed for CORE_LAT+1 cycles after reset instead of being flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= TAG_W'(NREQ - 1);
      inflight_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drain_q      <= DRN_W'(CORE_LAT + 1);
      din_q        <= '0;
      vin_q        <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drain_q      <= drain_d;
      din_q        <= din_d;
      vin_q        <= vin_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
  end

  assign req_if.req_ready  = grant_ok ? (NREQ'(1) << cand) : '0;
  assign req_if.resp_valid = resp_valid_q;
  assign req_if.resp_data  = resp_data_q;
  assign sqrt_din          = din_q;
  assign sqrt_vin          = vin_q;
  assign busy              = (inflight_q != '0) || drain_active;
  assign err               = err_q;

endmodule
